reg_slave: RTL and testbench
============================

REG_SLAVE -- requirements
Module: reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 16, SHALL set the number of general read/write registers at addresses 0x00..NUM_REGS-1 (legal range 1..240).
REQ-002 Parameter ID_VALUE, default 16'hC0DE, SHALL set the constant returned by the ID register.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 write  input  1  SHALL mean "write cycle" when 1 and "read cycle" when 0, sampled at posedge clk.
REQ-006 address  input  8  SHALL select the register, sampled at posedge clk.
REQ-007 data_in  input  16  SHALL carry the write data, sampled at posedge clk when write=1.
REQ-008 data_out  output  16  SHALL be registered read data.

Function
REQ-009 Address map SHALL be:
- 0x00..NUM_REGS-1: GP registers, RW.
- 0xF0: CTRL; bit0 LOCK, RW; bits 15:1 read 0.
- 0xF1: WRCNT, RO count of accepted writes; a write clears it.
- 0xF2: ERRCNT, RO count of rejected writes; a write clears it.
- 0xFF: ID, RO, returns ID_VALUE.
- All other addresses: unmapped.
REQ-010 Write with LOCK=0 to a GP address SHALL update that register at the same posedge and increment WRCNT.
REQ-011 Write with LOCK=1 to a GP address SHALL leave the register unchanged and increment ERRCNT.
REQ-012 Write to CTRL SHALL always be accepted, regardless of LOCK, and SHALL increment WRCNT.
REQ-013 Write to ID or to an unmapped address SHALL change no register and SHALL increment ERRCNT.
REQ-014 A write to WRCNT or ERRCNT SHALL clear that counter to 0, takes priority over any increment in the same cycle, and SHALL increment no counter.
REQ-015 WRCNT and ERRCNT SHALL saturate at 16'hFFFF; no wrap to 0.
REQ-016 Read cycle (write=0) SHALL load data_out at that posedge with the addressed register's current value; read latency is 1 cycle.
REQ-017 A read issued in the cycle immediately after a write to the same address SHALL return the newly written value; no bypass path is required because writes commit at the same edge.
REQ-018 A read of an unmapped address SHALL return 16'hDEAD and SHALL NOT increment any counter.
REQ-019 During write cycles data_out SHALL hold its previous value.
REQ-020 GP registers SHALL ignore address bits above those needed; addresses NUM_REGS..0xEF are unmapped.
REQ-021 Every cycle is independent; there is no busy or back-pressure state and one access is accepted per clock.

Reset
REQ-022 While rst=1 at posedge clk, the following SHALL be cleared to 0, and write/address/data_in SHALL be ignored: all GP registers, CTRL (LOCK=0), WRCNT, ERRCNT and data_out.
REQ-023 A reset asserted mid-sequence SHALL discard the in-flight access; the first access after rst deasserts SHALL see reset values.
REQ-024 No output SHALL be X after the first reset edge.

Structure
REQ-025 Shared package reg_slave_pkg SHALL hold the following constants: ADDR_CTRL=8'hF0, ADDR_WRCNT=8'hF1, ADDR_ERRCNT=8'hF2, ADDR_ID=8'hFF, UNMAPPED_DATA=16'hDEAD, LOCK_BIT=0.
REQ-026 A single sub-module sat_counter SHALL be used, instantiated twice, for WRCNT and ERRCNT.
- Ports: clk, rst, clr, inc, 16-bit count.
- clr has priority over inc.
REQ-027 The block SHALL be connectable to the team's reg_if slave modport: clk, write, data_in and address as inputs, data_out as output.

Verification
REQ-028 Scenario 1 SHALL check reset and read-back:
- Stimulus: reset, then write 16'h1234 to 0x03, then read 0x03 on the next cycle.
- Required response: data_out=16'h1234 one cycle after the read; WRCNT=1.
REQ-029 Scenario 2 SHALL check lock:
- Stimulus: write CTRL=1, write 16'hAAAA to 0x05, read 0x05, read 0xF2.
- Required response: 0x05 reads 0x0000; ERRCNT reads 1; WRCNT reads 1.
REQ-030 Scenario 3 SHALL check read-only and unmapped accesses:
- Stimulus: write to 0xFF and 0x80, then read 0xFF, 0x80, 0xF2.
- Required response: reads return 16'hC0DE, 16'hDEAD and 2 respectively.
REQ-031 Scenario 4 SHALL check saturation and clear:
- Stimulus: force 65537 accepted writes, read WRCNT, write 0xF1, read WRCNT.
- Required response: WRCNT reads 16'hFFFF, then 0.
REQ-032 Scenario 5 SHALL check reset mid-operation:
- Stimulus: write 16'h5555 to 0x00, assert rst for 1 cycle during a following read of 0x00, then read 0x00.
- Required response: data_out=0 during and after reset; 0x00 reads 0.
REQ-033 Scenario 6 SHALL check data_out hold:
- Stimulus: read 0x03 (value 16'h1234), then issue 3 consecutive writes.
- Required response: data_out stays 16'h1234 through all write cycles.

Source files
------------

// File: rtl/reg_slave_pkg.sv
// Shared constants for the reg_slave register block.
//   ADDR_*         fixed addresses of the control/status/ID registers
//   UNMAPPED_DATA  value returned when reading an unmapped address
//   LOCK_BIT       bit position of LOCK inside CTRL
package reg_slave_pkg;

  localparam logic [7:0]  ADDR_CTRL     = 8'hF0;
  localparam logic [7:0]  ADDR_WRCNT    = 8'hF1;
  localparam logic [7:0]  ADDR_ERRCNT   = 8'hF2;
  localparam logic [7:0]  ADDR_ID       = 8'hFF;
  localparam logic [15:0] UNMAPPED_DATA = 16'hDEAD;
  localparam int unsigned LOCK_BIT      = 0;

endpackage

// File: rtl/reg_slave_if.sv
// Register access bus: one access per clock, write=1 write cycle, write=0 read cycle.
//   clk       bus clock (carried for completeness; the slave also takes clk as a plain port)
//   write     1 = write, 0 = read
//   address   8-bit register address
//   data_in   16-bit write data
//   data_out  16-bit registered read data
interface reg_slave_if (
  input logic clk
);

  logic        write;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (
    input  clk,
    output write,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  clk,
    input  write,
    input  address,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/sat_counter.sv
// 16-bit saturating up-counter with synchronous clear.
//   clk    clock
//   rst    synchronous active-high reset (count -> 0)
//   clr    clear to 0; wins over inc
//   inc    increment by one, sticking at 16'hFFFF
//   count  current count
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_slave.sv
// Register slave: NUM_REGS general-purpose RW registers, a CTRL register with a
// write LOCK, saturating accepted/rejected write counters and a constant ID.
//   clk   clock, all state changes on posedge
//   rst   synchronous active-high reset
//   bus   reg_slave_if slave modport (write, address, data_in in; data_out out)
module reg_slave
  import reg_slave_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [15:0] ID_VALUE = 16'hC0DE
) (
  input logic          clk,
  input logic          rst,
  reg_slave_if.slave   bus
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [15:0]     gp_q [NUM_REGS];
  logic            lock_q;
  logic [15:0]     data_out_q;
  logic [15:0]     wrcnt, errcnt;

  logic [IdxW-1:0] gp_idx;
  logic            is_gp, is_ctrl, is_wrcnt, is_errcnt;
  logic            gp_we, ctrl_we, wr_accept, wr_reject;
  logic [15:0]     ctrl_rd, rdata;

  // Decode
  assign gp_idx    = bus.address[IdxW-1:0];
  assign is_gp     = 32'(bus.address) < NUM_REGS;
  assign is_ctrl   = bus.address == ADDR_CTRL;
  assign is_wrcnt  = bus.address == ADDR_WRCNT;
  assign is_errcnt = bus.address == ADDR_ERRCNT;

  assign gp_we   = bus.write && is_gp && !lock_q;
  assign ctrl_we = bus.write && is_ctrl;

  assign wr_accept = gp_we || ctrl_we;
  // Counter writes are neither accepted nor rejected; everything else that is
  // not a GP/CTRL write (ID, unmapped, locked GP) counts as rejected.
  assign wr_reject = bus.write &&
                     ((is_gp && lock_q) || !(is_gp || is_ctrl || is_wrcnt || is_errcnt));

  // State
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        gp_q[i] <= '0;
      end
      lock_q <= 1'b0;
    end else begin
      if (gp_we) begin
        gp_q[gp_idx] <= bus.data_in;
      end
      if (ctrl_we) begin
        lock_q <= bus.data_in[LOCK_BIT];
      end
    end
  end

  sat_counter u_wrcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.write && is_wrcnt),
    .inc   (wr_accept),
    .count (wrcnt)
  );

  sat_counter u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.write && is_errcnt),
    .inc   (wr_reject),
    .count (errcnt)
  );

  // Read mux
  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd[LOCK_BIT] = lock_q;
    rdata             = UNMAPPED_DATA;
    if (is_gp) begin
      rdata = gp_q[gp_idx];
    end else begin
      case (bus.address)
        ADDR_CTRL:   rdata = ctrl_rd;
        ADDR_WRCNT:  rdata = wrcnt;
        ADDR_ERRCNT: rdata = errcnt;
        ADDR_ID:     rdata = ID_VALUE;
        default:     rdata = UNMAPPED_DATA;
      endcase
    end
  end

  // data_out only loads on read cycles and holds through writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (!bus.write) begin
      data_out_q <= rdata;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_reg_slave.sv
// Directed self-checking bench for reg_slave.
module tb_reg_slave;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_slave_if bus (.clk(clk));

  reg_slave #(
    .NUM_REGS (16),
    .ID_VALUE (16'hC0DE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access; returns 1 ns after the sampling edge.
  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d);
    bus.write   = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    access(1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    access(1'b0, a, 16'h0000);
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (bus.data_out === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.data_out, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.write   = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 16'h0000;

    // Reset with inputs active: they must be ignored.
    access(1'b1, 8'h03, 16'hFFFF);
    access(1'b0, 8'hFF, 16'h0000);
    check("reset_data_out", 16'h0000);
    rst = 1'b0;

    rd(8'hF1); check("reset_wrcnt", 16'h0000);
    rd(8'hF2); check("reset_errcnt", 16'h0000);
    rd(8'hF0); check("reset_ctrl", 16'h0000);
    rd(8'h03); check("reset_gp03", 16'h0000);
    rd(8'hFF); check("id_read", 16'hC0DE);

    // Scenario 1: write then read back next cycle.
    wr(8'h03, 16'h1234);
    rd(8'h03); check("s1_readback", 16'h1234);
    rd(8'hF1); check("s1_wrcnt", 16'h0001);

    // Scenario 6: data_out holds through writes.
    rd(8'h03); check("s6_read", 16'h1234);
    wr(8'h06, 16'h1111); check("s6_hold1", 16'h1234);
    wr(8'h07, 16'h2222); check("s6_hold2", 16'h1234);
    wr(8'h08, 16'h3333); check("s6_hold3", 16'h1234);
    rd(8'hF1); check("s6_wrcnt", 16'h0004);
    rd(8'h07); check("s6_gp07", 16'h2222);

    // Clearing WRCNT does not count as an accepted write.
    wr(8'hF1, 16'h9999);
    rd(8'hF1); check("wrcnt_clear", 16'h0000);

    // Scenario 2: lock blocks GP writes.
    wr(8'hF0, 16'h0001);
    wr(8'h05, 16'hAAAA);
    rd(8'h05); check("s2_gp05_locked", 16'h0000);
    rd(8'hF2); check("s2_errcnt", 16'h0001);
    rd(8'hF1); check("s2_wrcnt", 16'h0001);
    rd(8'hF0); check("s2_ctrl", 16'h0001);
    rd(8'h03); check("s2_gp03_kept", 16'h1234);

    // Unlock while locked; upper CTRL bits read 0.
    wr(8'hF0, 16'hFFFE);
    rd(8'hF0); check("ctrl_unlock", 16'h0000);
    rd(8'hF1); check("ctrl_wr_counted", 16'h0002);

    // Scenario 3: RO and unmapped writes, with ERRCNT cleared first.
    wr(8'hF2, 16'h0000);
    wr(8'hFF, 16'h1111);
    wr(8'h80, 16'h2222);
    rd(8'hFF); check("s3_id", 16'hC0DE);
    rd(8'h80); check("s3_unmapped", 16'hDEAD);
    rd(8'hF2); check("s3_errcnt", 16'h0002);
    rd(8'hF1); check("s3_wrcnt_unchanged", 16'h0002);

    // GP range boundary: 0x0F is the last register, 0x10 is unmapped.
    wr(8'h0F, 16'hBEEF);
    wr(8'h10, 16'h4444);
    rd(8'h0F); check("gp_last", 16'hBEEF);
    rd(8'h10); check("gp_past_end", 16'hDEAD);
    rd(8'hF2); check("past_end_errcnt", 16'h0003);

    // Scenario 4: saturation and clear.
    wr(8'hF1, 16'h0000);
    for (int i = 0; i < 65535; i++) begin
      wr(8'h01, 16'(i));
    end
    rd(8'hF1); check("s4_wrcnt_max", 16'hFFFF);
    wr(8'h01, 16'h0077);
    wr(8'h01, 16'h0088);
    rd(8'hF1); check("s4_wrcnt_sat", 16'hFFFF);
    rd(8'h01); check("s4_gp01", 16'h0088);
    wr(8'hF1, 16'h0000);
    rd(8'hF1); check("s4_wrcnt_cleared", 16'h0000);

    // Scenario 5: reset during a read discards it.
    wr(8'h00, 16'h5555);
    wr(8'hF0, 16'h0001);
    rst = 1'b1;
    rd(8'h00); check("s5_during_reset", 16'h0000);
    rst = 1'b0;
    rd(8'h00); check("s5_gp00_after", 16'h0000);
    rd(8'hF0); check("s5_ctrl_after", 16'h0000);
    rd(8'hF1); check("s5_wrcnt_after", 16'h0000);
    rd(8'h03); check("s5_gp03_after", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
